pc_control_unit: RTL and testbench
==================================

Name: pc_control_unit

Overview:
Program-counter stage of the multicycle MIPS datapath. Holds PC and EPC and selects the next PC from PC+4, the branch target, the jump target or EPC. Builds the jump target internally as {PC[31:28], instr_index, 2'b00}, consuming the same fields as the jump shift-left stage. Runs the exception vector fetch: saves EPC, reads the vector byte from memory, then loads PC from it.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
VEC_OPCODE, 32'd253, memory address of the vector byte for an invalid opcode
VEC_OVERFLOW, 32'd254, memory address of the vector byte for an overflow
VEC_DIVZERO, 32'd255, memory address of the vector byte for divide-by-zero
MEM_LATENCY, 1, cycles from read address to sampled data; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
pc_write  in  1  unconditional PC load
pc_write_cond  in  1  PC load qualified by branch_cond
branch_cond  in  1  resolved branch condition from the ALU flags
pc_source  in  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 epc
alu_result  in  32  combinational ALU result (PC+4 during fetch)
alu_out  in  32  registered ALU output (branch target)
instr_index  in  26  IR[25:0]
exc_req  in  1  exception request, one-cycle pulse from control
exc_cause  in  2  00 opcode, 01 overflow, 10 divzero, 11 reserved
mem_data_byte  in  8  byte read from memory
pc  out  32  current PC
epc  out  32  saved exception PC
jump_target  out  32  {pc[31:28], instr_index, 2'b00}, combinational
exc_mem_addr  out  32  vector address
exc_mem_read  out  1  memory read request for the vector fetch
busy  out  1  exception sequence in progress

Behaviour:
- All state updates on the rising clk edge. reset dominates all other inputs.
- Reset: pc=RESET_PC, epc=0, state=IDLE, exc_mem_read=0, exc_mem_addr=0, busy=0, wait counter=0.
- Reset during ADDR or WAIT aborts the sequence with the same reset values; no PC load occurs.
- jump_target is purely combinational from the current pc and instr_index, with no added latency.
- State machine: IDLE, ADDR, WAIT.
- IDLE, exc_req=1 and exc_cause!=11:
  - epc <= pc - 4 (modulo 2^32, so pc=0 gives epc=32'hFFFF_FFFC).
  - exc_mem_addr <= vector for the cause; exc_mem_read <= 1.
  - go to ADDR.
  - pc is not updated this cycle; exc_req has priority over pc_write/pc_write_cond in the same cycle.
- IDLE, exc_req=1 and exc_cause=11: the request is ignored and the normal PC update applies.
- IDLE, no accepted exception:
  - if pc_write | (pc_write_cond & branch_cond), pc <= mux(pc_source); otherwise pc holds.
  - pc_source=11 loads the current epc.
  - No alignment check on the loaded value.
- ADDR (one cycle): exc_mem_read=1, busy=1; load the counter with MEM_LATENCY-1; go to WAIT.
- WAIT:
  - exc_mem_read=1, busy=1, exc_mem_addr held.
  - While the counter is nonzero, decrement it.
  - At the edge ending the cycle with counter==0: pc <= {24'b0, mem_data_byte}, exc_mem_read <= 0, exc_mem_addr <= 0, go to IDLE.
- With MEM_LATENCY=1: exc_req sampled at edge E0, ADDR during E0-E1, WAIT during E1-E2, new pc visible after E2.
- busy is high exactly in ADDR and WAIT. While busy, pc_write, pc_write_cond and exc_req are ignored; a second exception is dropped, not queued.
- epc changes only on an accepted exception or on reset.

Test Plan:
- Reset then jump: reset for 2 cycles -> pc=0, busy=0. Load pc=32'hE000_0010 via pc_source=00 (alu_result), then instr_index=26'h21EAAA, pc_source=10, pc_write=1 -> jump_target=32'hE087_AAA8 combinationally; pc=32'hE087_AAA8 after the edge.
- Conditional branch: pc_write_cond=1, alu_out=32'h0000_0040, pc_source=01. branch_cond=0 -> pc unchanged. branch_cond=1 -> pc=32'h40.
- Overflow exception: pc=32'h0000_0108, exc_req=1, exc_cause=01, and pc_write=1 in the same cycle -> pc_write ignored; epc=32'h104; exc_mem_addr=254 and exc_mem_read=1 for 2 cycles. With mem_data_byte=8'h7C presented, pc=32'h0000_007C 2 edges after the request; busy=0 after.
- Busy lockout: during WAIT, assert pc_write=1 and exc_req=1 with exc_cause=10 -> no effect; pc becomes only the vector byte; epc unchanged.
- Reset mid-sequence: reset asserted while in ADDR -> next edge pc=RESET_PC, epc=0, exc_mem_read=0, busy=0; no vector load afterwards.
- Reserved cause and return: exc_cause=11 with pc_write=1, pc_source=00, alu_result=32'h8 -> pc=32'h8, no sequence started. Then pc_source=11, pc_write=1 -> pc=epc.

Source files
------------

// File: rtl/pc_control_unit_if.sv
// Bus between control/datapath and the PC stage. The master drives the control
// inputs; the slave (pc_control_unit) drives PC, EPC and the vector-fetch signals.
interface pc_control_unit_if;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_cond;
    logic [1:0]  pc_source;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [25:0] instr_index;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [7:0]  mem_data_byte;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] jump_target;
    logic [31:0] exc_mem_addr;
    logic        exc_mem_read;
    logic        busy;

    modport master (
        output pc_write, pc_write_cond, branch_cond, pc_source, alu_result, alu_out,
               instr_index, exc_req, exc_cause, mem_data_byte,
        input  pc, epc, jump_target, exc_mem_addr, exc_mem_read, busy
    );

    modport slave (
        input  pc_write, pc_write_cond, branch_cond, pc_source, alu_result, alu_out,
               instr_index, exc_req, exc_cause, mem_data_byte,
        output pc, epc, jump_target, exc_mem_addr, exc_mem_read, busy
    );
endinterface

// File: rtl/pc_control_unit.sv
// Program-counter stage of the multicycle MIPS datapath: PC/EPC registers,
// next-PC selection and the exception vector fetch sequence.
module pc_control_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] VEC_OPCODE   = 32'd253,
    parameter logic [31:0] VEC_OVERFLOW = 32'd254,
    parameter logic [31:0] VEC_DIVZERO  = 32'd255,
    parameter int unsigned MEM_LATENCY  = 1
) (
    input logic              clk,
    input logic              reset,
    pc_control_unit_if.slave bus
);
    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StAddr, StWait} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       epc_q, epc_d;
    logic [31:0]       addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       next_pc;
    logic [31:0]       vec_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0;
            addr_q  <= 32'h0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;

        unique case (bus.pc_source)
            2'b00:   next_pc = bus.alu_result;
            2'b01:   next_pc = bus.alu_out;
            2'b10:   next_pc = {pc_q[31:28], bus.instr_index, 2'b00};
            default: next_pc = epc_q;
        endcase

        unique case (bus.exc_cause)
            2'b00:   vec_addr = VEC_OPCODE;
            2'b01:   vec_addr = VEC_OVERFLOW;
            default: vec_addr = VEC_DIVZERO;
        endcase

        unique case (state_q)
            StIdle: begin
                // Exception takes priority over any PC write; cause 11 is ignored.
                if (bus.exc_req && (bus.exc_cause != 2'b11)) begin
                    epc_d   = pc_q - 32'd4;
                    addr_d  = vec_addr;
                    rd_d    = 1'b1;
                    state_d = StAddr;
                end else if (bus.pc_write || (bus.pc_write_cond && bus.branch_cond)) begin
                    pc_d = next_pc;
                end
            end
            StAddr: begin
                cnt_d   = CntW'(MEM_LATENCY - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    pc_d    = {24'h0, bus.mem_data_byte};
                    rd_d    = 1'b0;
                    addr_d  = 32'h0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.pc           = pc_q;
        bus.epc          = epc_q;
        bus.jump_target  = {pc_q[31:28], bus.instr_index, 2'b00};
        bus.exc_mem_addr = addr_q;
        bus.exc_mem_read = rd_q;
        bus.busy         = (state_q != StIdle);
    end
endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: directed scenarios followed by random
// stimulus, checked against a cycle-count reference model.
module tb_pc_control_unit;
    localparam int unsigned ML = 1;

    typedef struct {
        bit          rst, pw, pwc, bc, er;
        logic [1:0]  src, cause;
        logic [31:0] res, aout;
        logic [25:0] idx;
        logic [7:0]  mbyte;
    } stim_t;

    typedef struct {
        logic [31:0] pc, epc, addr, jt;
        bit          rd, busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    pc_control_unit_if bus ();

    pc_control_unit #(.MEM_LATENCY(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    stim_t       s;
    int          n_chk = 0;
    int          n_err = 0;

    // Reference model: an exception sequence is just a countdown of edges to the vector load.
    logic [31:0] m_pc, m_epc, m_addr;
    bit          m_rd;
    int          m_left;

    function automatic logic [31:0] vec_of(input logic [1:0] c);
        logic [31:0] v;
        v = 32'd253 + {30'd0, c};
        return v;
    endfunction

    task automatic clr();
        s = '{default: '0};
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        reset             = s.rst;
        bus.pc_write      = s.pw;
        bus.pc_write_cond = s.pwc;
        bus.branch_cond   = s.bc;
        bus.pc_source     = s.src;
        bus.alu_result    = s.res;
        bus.alu_out       = s.aout;
        bus.instr_index   = s.idx;
        bus.exc_req       = s.er;
        bus.exc_cause     = s.cause;
        bus.mem_data_byte = s.mbyte;

        if (s.rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_addr = 32'h0; m_rd = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_pc   = {24'h0, s.mbyte};
                m_rd   = 0;
                m_addr = 32'h0;
            end
        end else if (s.er && s.cause != 2'b11) begin
            m_epc  = m_pc - 32'd4;
            m_addr = vec_of(s.cause);
            m_rd   = 1;
            m_left = ML + 1;
        end else if (s.pw || (s.pwc && s.bc)) begin
            case (s.src)
                2'b00:   m_pc = s.res;
                2'b01:   m_pc = s.aout;
                2'b10:   m_pc = {m_pc[31:28], s.idx, 2'b00};
                default: m_pc = m_epc;
            endcase
        end
        e.pc   = m_pc;
        e.epc  = m_epc;
        e.addr = m_addr;
        e.rd   = m_rd;
        e.busy = (m_left > 0);
        e.jt   = {m_pc[31:28], s.idx, 2'b00};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: DUT presents a fresh state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", bus.pc, e.pc);
                chk("epc", bus.epc, e.epc);
                chk("exc_mem_addr", bus.exc_mem_addr, e.addr);
                chk("exc_mem_read", {31'd0, bus.exc_mem_read}, {31'd0, e.rd});
                chk("busy", {31'd0, bus.busy}, {31'd0, e.busy});
                chk("jump_target", bus.jump_target, e.jt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        clr(); s.rst = 1; step(); step();

        // Load a PC then jump.
        clr(); s.pw = 1; s.src = 2'b00; s.res = 32'hE000_0010; step();
        clr(); s.pw = 1; s.src = 2'b10; s.idx = 26'h21EAAA; step();

        // Conditional branch, not taken then taken.
        clr(); s.pwc = 1; s.src = 2'b01; s.aout = 32'h40; s.bc = 0; step();
        s.bc = 1; step();

        // Overflow exception with a simultaneous pc_write.
        clr(); s.pw = 1; s.res = 32'h108; step();
        clr(); s.er = 1; s.cause = 2'b01; s.pw = 1; s.res = 32'hDEAD_BEEF; step();
        clr(); s.mbyte = 8'h7C; step(); step();
        clr(); step();

        // Busy lockout: writes and a second exception during WAIT are dropped.
        clr(); s.pw = 1; s.res = 32'h200; step();
        clr(); s.er = 1; s.cause = 2'b00; step();
        clr(); step();
        clr(); s.pw = 1; s.res = 32'h1234; s.er = 1; s.cause = 2'b10; s.mbyte = 8'h55; step();
        clr(); step();

        // Reserved cause is ignored; then return via EPC.
        clr(); s.er = 1; s.cause = 2'b11; s.pw = 1; s.src = 2'b00; s.res = 32'h8; step();
        clr(); s.pw = 1; s.src = 2'b11; step();

        // Reset while in ADDR aborts the sequence.
        clr(); s.er = 1; s.cause = 2'b10; step();
        clr(); s.rst = 1; s.mbyte = 8'hAA; step();
        clr(); s.mbyte = 8'hBB; step(); step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 59) == 0);
            s.pw    = ($urandom_range(0, 2) == 0);
            s.pwc   = $urandom_range(0, 1) != 0;
            s.bc    = $urandom_range(0, 1) != 0;
            s.er    = ($urandom_range(0, 5) == 0);
            s.src   = 2'($urandom_range(0, 3));
            s.cause = 2'($urandom_range(0, 3));
            s.res   = $urandom;
            s.aout  = $urandom;
            s.idx   = 26'($urandom);
            s.mbyte = 8'($urandom);
            step();
        end

        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
